m_fetch_queue: RTL and testbench

- Instruction-fetch front end for the m_proc5 5-stage RISC-V pipeline.
- Sits between instruction memory and the decode stage.
- Owns the fetch PC and prefetches sequential words into a small FIFO of {pc, ir} pairs.
- Presents the head entry to decode with a valid/ready handshake, and flushes and redirects on a taken branch or jump from the execute stage.

---
 rtl/m_fetch_queue_pkg.sv | 21 ++
 rtl/m_fetch_queue_if.sv | 27 ++
 rtl/m_fetch_queue_fifo.sv | 72 +++++++
 rtl/m_fetch_queue.sv | 72 +++++++
 tb/tb_m_fetch_queue.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/m_fetch_queue_pkg.sv
// Shared definitions for the fetch queue: machine widths, the nop encoding,
// the {pc, ir} entry type and a word-alignment helper.
package m_fetch_queue_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] ir;
    } fq_entry_t;

    // Clear the byte-offset bits so the fetch PC is always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/m_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory port, execute redirect and the
// decode-side valid/ready handshake.
//   master : the fetch queue (drives imem address and the head entry)
//   slave  : the surrounding pipeline / memory (drives data, redirect, ready)
interface m_fetch_queue_if;
    import m_fetch_queue_pkg::*;

    logic [XLEN-1:0] w_imem_addr;
    logic [ILEN-1:0] w_imem_data;
    logic            w_redirect;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_valid;
    logic            w_ready;
    logic [XLEN-1:0] w_pc;
    logic [ILEN-1:0] w_ir;

    modport master (
        output w_imem_addr, w_valid, w_pc, w_ir,
        input  w_imem_data, w_redirect, w_redirect_pc, w_ready
    );

    modport slave (
        input  w_imem_addr, w_valid, w_pc, w_ir,
        output w_imem_data, w_redirect, w_redirect_pc, w_ready
    );

endinterface

// File: rtl/m_fetch_queue_fifo.sv
// DEPTH-entry register FIFO of {pc, ir} pairs with push, pop and flush.
//   w_clk, w_rst : clock, asynchronous active-high reset
//   push_i/wdata_i : write wdata_i at the tail
//   pop_i          : advance the head
//   flush_i        : empty the queue; overrides push and pop
//   rdata_o        : head entry (combinational from storage)
//   count_o        : number of valid entries, 0..DEPTH
// Caller guarantees no push when full without pop, and no pop when empty.
module m_fetch_queue_fifo
    import m_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     w_clk,
    input  logic                     w_rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  fq_entry_t                wdata_i,
    output fq_entry_t                rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    fq_entry_t        mem_q [DEPTH];
    fq_entry_t        mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + (PtrW+1)'(push_i) - (PtrW+1)'(pop_i);
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/m_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, prefetches sequential words
// into a small FIFO and presents the head entry to decode. A redirect from
// execute flushes the queue and restarts fetch at the (word-aligned) target.
//   w_clk, w_rst : clock, asynchronous active-high reset
//   bus          : imem address/data, redirect, decode valid/ready/pc/ir
module m_fetch_queue
    import m_fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic             w_clk,
    input  logic             w_rst,
    m_fetch_queue_if.master  bus
);

    localparam int unsigned     PtrW   = $clog2(DEPTH);
    localparam logic [PtrW:0]   DepthC = (PtrW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PtrW:0]   count;
    fq_entry_t       head;
    fq_entry_t       wdata;
    logic            valid;
    logic            pop;
    logic            push;

    assign valid = (count != '0);
    assign pop   = valid && bus.w_ready;
    // A full queue can still accept a word when the head leaves this cycle.
    assign push  = !bus.w_redirect && ((count < DepthC) || pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.w_redirect) begin
            fetch_pc_d = word_align(bus.w_redirect_pc);
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign wdata.pc = fetch_pc_q;
    assign wdata.ir = bus.w_imem_data;

    m_fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .w_clk   (w_clk),
        .w_rst   (w_rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.w_redirect),
        .wdata_i (wdata),
        .rdata_o (head),
        .count_o (count)
    );

    assign bus.w_imem_addr = fetch_pc_q;
    assign bus.w_valid     = valid;
    // Stale storage is hidden whenever the queue is empty.
    assign bus.w_pc        = valid ? head.pc : '0;
    assign bus.w_ir        = valid ? head.ir : NOP;

endmodule

// File: tb/tb_m_fetch_queue.sv
// Directed bench for m_fetch_queue. Instruction memory returns word_index+100.
module tb_m_fetch_queue;

    logic w_clk;
    logic w_rst;
    int   n_tests;
    int   n_fail;

    m_fetch_queue_if u_if_a ();
    m_fetch_queue_if u_if_b ();

    m_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) u_dut_a (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .bus   (u_if_a)
    );

    m_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h100)
    ) u_dut_b (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .bus   (u_if_b)
    );

    assign u_if_a.w_imem_data = {2'b00, u_if_a.w_imem_addr[31:2]} + 32'd100;
    assign u_if_b.w_imem_data = {2'b00, u_if_b.w_imem_addr[31:2]} + 32'd100;

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] ir);
        chk({tag, "_valid"}, {31'd0, u_if_a.w_valid}, 32'd1);
        chk({tag, "_pc"}, u_if_a.w_pc, pc);
        chk({tag, "_ir"}, u_if_a.w_ir, ir);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        w_rst   = 1'b1;
        u_if_a.w_ready       = 1'b0;
        u_if_a.w_redirect    = 1'b0;
        u_if_a.w_redirect_pc = 32'h0;
        u_if_b.w_ready       = 1'b1;
        u_if_b.w_redirect    = 1'b0;
        u_if_b.w_redirect_pc = 32'h0;
        #1;
        // Reset state
        chk("rst_valid", {31'd0, u_if_a.w_valid}, 32'd0);
        chk("rst_pc", u_if_a.w_pc, 32'h0);
        chk("rst_ir", u_if_a.w_ir, 32'h13);
        chk("rst_addr", u_if_a.w_imem_addr, 32'h0);
        chk("rst_addr_b", u_if_b.w_imem_addr, 32'h100);

        // 1: streaming with ready=1
        u_if_a.w_ready = 1'b1;
        @(negedge w_clk);
        w_rst = 1'b0;
        #1;
        chk("t1_valid_pre", {31'd0, u_if_a.w_valid}, 32'd0);
        tick();
        head("t1_e0", 32'h0, 32'd100);
        tick();
        head("t1_e1", 32'h4, 32'd101);
        tick();
        head("t1_e2", 32'h8, 32'd102);

        // 2: stall for 10 cycles from a fresh reset, then drain
        w_rst = 1'b1;
        #1;
        chk("t2_rst_valid", {31'd0, u_if_a.w_valid}, 32'd0);
        u_if_a.w_ready = 1'b0;
        @(negedge w_clk);
        w_rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        head("t2_stall", 32'h0, 32'd100);
        chk("t2_addr", u_if_a.w_imem_addr, 32'h10);
        u_if_a.w_ready = 1'b1;
        tick();
        head("t2_d1", 32'h4, 32'd101);
        tick();
        head("t2_d2", 32'h8, 32'd102);
        tick();
        head("t2_d3", 32'hC, 32'd103);
        tick();
        head("t2_d4", 32'h10, 32'd104);

        // 3: redirect to 0x40 with 3 entries queued
        w_rst = 1'b1;
        #1;
        u_if_a.w_ready = 1'b0;
        @(negedge w_clk);
        w_rst = 1'b0;
        tick();
        tick();
        tick();
        chk("t3_addr_pre", u_if_a.w_imem_addr, 32'hC);
        u_if_a.w_redirect    = 1'b1;
        u_if_a.w_redirect_pc = 32'h40;
        u_if_a.w_ready       = 1'b1;
        tick();
        u_if_a.w_redirect = 1'b0;
        chk("t3_bubble_valid", {31'd0, u_if_a.w_valid}, 32'd0);
        chk("t3_bubble_ir", u_if_a.w_ir, 32'h13);
        chk("t3_addr", u_if_a.w_imem_addr, 32'h40);
        tick();
        head("t3_e0", 32'h40, 32'd116);
        tick();
        head("t3_e1", 32'h44, 32'd117);

        // 4: redirect to 0x43 coinciding with a pop from a full queue
        u_if_a.w_ready = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("t4_full_addr", u_if_a.w_imem_addr, 32'h54);
        head("t4_full_head", 32'h44, 32'd117);
        u_if_a.w_ready       = 1'b1;
        u_if_a.w_redirect    = 1'b1;
        u_if_a.w_redirect_pc = 32'h43;
        tick();
        u_if_a.w_redirect = 1'b0;
        chk("t4_bubble_valid", {31'd0, u_if_a.w_valid}, 32'd0);
        chk("t4_addr", u_if_a.w_imem_addr, 32'h40);
        tick();
        head("t4_e0", 32'h40, 32'd116);
        // Back-to-back redirects, last wins
        u_if_a.w_redirect    = 1'b1;
        u_if_a.w_redirect_pc = 32'h80;
        tick();
        chk("t4_bb1_valid", {31'd0, u_if_a.w_valid}, 32'd0);
        chk("t4_bb1_addr", u_if_a.w_imem_addr, 32'h80);
        u_if_a.w_redirect_pc = 32'hC0;
        tick();
        u_if_a.w_redirect = 1'b0;
        chk("t4_bb2_valid", {31'd0, u_if_a.w_valid}, 32'd0);
        chk("t4_bb2_addr", u_if_a.w_imem_addr, 32'hC0);
        tick();
        head("t4_c0", 32'hC0, 32'd148);
        tick();
        head("t4_c4", 32'hC4, 32'd149);

        // 5: asynchronous reset mid-cycle with a full queue
        u_if_a.w_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_full_addr", u_if_a.w_imem_addr, 32'hD4);
        #2;
        w_rst = 1'b1;
        #1;
        chk("t5_async_valid", {31'd0, u_if_a.w_valid}, 32'd0);
        chk("t5_async_ir", u_if_a.w_ir, 32'h13);
        chk("t5_async_addr", u_if_a.w_imem_addr, 32'h0);
        chk("t5_async_valid_b", {31'd0, u_if_b.w_valid}, 32'd0);
        u_if_a.w_ready = 1'b1;
        @(negedge w_clk);
        w_rst = 1'b0;
        tick();
        head("t5_e0", 32'h0, 32'd100);
        chk("t5_b_valid", {31'd0, u_if_b.w_valid}, 32'd1);
        chk("t5_b_pc", u_if_b.w_pc, 32'h100);
        chk("t5_b_ir", u_if_b.w_ir, 32'd164);

        // 6: fetch PC wraps past 2^32
        u_if_a.w_redirect    = 1'b1;
        u_if_a.w_redirect_pc = 32'hFFFF_FFFC;
        tick();
        u_if_a.w_redirect = 1'b0;
        chk("t6_bubble_valid", {31'd0, u_if_a.w_valid}, 32'd0);
        tick();
        head("t6_top", 32'hFFFF_FFFC, 32'h4000_0063);
        tick();
        head("t6_wrap", 32'h0, 32'd100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
